uart_rx_oversampler: RTL

UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

---
 rtl/uart_rx_oversampler_if.sv | 28 ++
 rtl/uart_rx_oversampler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler_if.sv
// Signal bundle between the oversampling UART receiver and its consumer.
// NrD and FE are single-cycle strobes with no backpressure; O_DATA is valid from the NrD cycle until the next NrD.
interface uart_rx_oversampler_if;
  logic       Rx;
  logic [7:0] O_DATA;
  logic       NrD;
  logic       FE;
  logic       RiP;
  logic [2:0] state;

  modport master (
    input  Rx,
    output O_DATA,
    output NrD,
    output FE,
    output RiP,
    output state
  );

  modport slave (
    output Rx,
    input  O_DATA,
    input  NrD,
    input  FE,
    input  RiP,
    input  state
  );
endinterface

// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver: counter-based mid-bit sampling of a synchronized serial line.
// Reports good bytes on NrD, bad stop bits on FE, and waits out break conditions.
module uart_rx_oversampler #(
  parameter int BAUD_DIVIDER = 104
) (
  input  logic clk,
  input  logic rst,
  uart_rx_oversampler_if.master bus
);

  localparam int CW = $clog2(BAUD_DIVIDER);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIVIDER - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_q, data_n;
  logic          nrd_q, nrd_n;
  logic          fe_q, fe_n;
  logic          rx_meta, rx_s;

  // Synchronizer resets to idle-high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.Rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      nrd_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      data_q <= data_n;
      nrd_q  <= nrd_n;
      fe_q   <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    nrd_n   = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Half a bit in: a high line here means the falling edge was a glitch.
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            nrd_n   = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.O_DATA = data_q;
  assign bus.NrD    = nrd_q;
  assign bus.FE     = fe_q;
  assign bus.RiP    = (state != IDLE);
  assign bus.state  = state;

endmodule
